operand_loader: RTL

Front-end stage for the `(a-b)*(1+3c)-4d >>> 1` datapath. It accepts a serial stream of signed words over a valid/ready handshake and assembles them into the four operands `a`, `b`, `c` and `d`. It then presents them stably to the free-running compute stage, waits out that stage's latency, and captures its `2*WIDTH` result into a handshaked output register.

---
 rtl/operand_loader_pkg.sv | 27 ++
 rtl/operand_loader_result_reg.sv | 43 ++++
 rtl/operand_loader.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader front-end:
// FSM encoding, word-index width and the saturating sync-error counter.
package operand_loader_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FULL  = 2'd3
   } state_t;

   localparam int NUM_OPND = 4;
   localparam int IDX_W    = 2;

   localparam int                    SYNC_ERR_W   = 8;
   localparam logic [SYNC_ERR_W-1:0] SYNC_ERR_MAX = '1;

   function automatic logic [SYNC_ERR_W-1:0] sat_inc(input logic [SYNC_ERR_W-1:0] v);
      logic [SYNC_ERR_W-1:0] r;
      r = v;
      if (v != SYNC_ERR_MAX) begin
         r = v + 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/operand_loader_result_reg.sv
// One-entry valid/ready holding register for the captured compute result.
// A drain and a capture on the same edge keep the entry valid with new data.
module result_reg #(
   parameter int DW = 16
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          capture,
   input  logic          drain,
   input  logic [DW-1:0] cap_data,
   output logic          valid,
   output logic [DW-1:0] data
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (valid_q && drain) begin
         valid_d = 1'b0;
      end
      if (capture) begin
         valid_d = 1'b1;
         data_d  = cap_data;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/operand_loader.sv
// Serial-to-parallel operand loader for the (a-b)*(1+3c)-4d >>> 1 datapath:
// collects four words, holds them for the external compute stage, captures its result.
module operand_loader
   import operand_loader_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CALC_LAT = 1
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_sop,
   input  logic [WIDTH-1:0]      in_data,
   output logic [WIDTH-1:0]      a,
   output logic [WIDTH-1:0]      b,
   output logic [WIDTH-1:0]      c,
   output logic [WIDTH-1:0]      d,
   output logic                  op_valid,
   input  logic [2*WIDTH-1:0]    y_in,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [2*WIDTH-1:0]    res_data,
   output logic [SYNC_ERR_W-1:0] sync_err
);

   localparam int               CNT_W    = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CALC_LAT - 1);

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SYNC_ERR_W-1:0]   sync_err_q, sync_err_d;
   logic                    rdy_en_q, rdy_en_d;

   logic                    accept;
   logic                    last_word;
   logic                    wait_last;
   logic                    res_free;
   logic                    capture;
   logic [NUM_OPND-1:0]     load_en;
   logic [WIDTH-1:0]        opnd [NUM_OPND];

   assign accept    = in_valid && in_ready;
   assign last_word = accept && !in_sop && (idx_q == IDX_W'(NUM_OPND - 1));
   assign wait_last = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
   assign res_free  = !res_valid || res_ready;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_LOAD: begin
            if (last_word) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_last) begin
               state_d = res_free ? ST_LOAD : ST_FULL;
            end
         end
         ST_FULL: begin
            if (res_ready) begin
               state_d = ST_LOAD;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // in_ready depends only on registered state, never on in_valid or res_ready.
   always_comb begin
      in_ready = 1'b0;
      op_valid = 1'b0;
      capture  = 1'b0;
      unique case (state_q)
         ST_LOAD:  in_ready = rdy_en_q;
         ST_ISSUE: op_valid = 1'b1;
         ST_WAIT:  capture  = wait_last && res_free;
         ST_FULL:  capture  = res_ready;
         default:  in_ready = 1'b0;
      endcase
   end

   // ---------------- latency counter and word index ----------------
   always_comb begin
      cnt_d = '0;
      if (state_q == ST_WAIT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      idx_d      = idx_q;
      sync_err_d = sync_err_q;
      if (accept) begin
         if (in_sop) begin
            idx_d = IDX_W'(1);
            if (idx_q != '0) begin
               sync_err_d = sat_inc(sync_err_q);
            end
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // A start-of-set word always lands in slot 0, whatever the current index.
   always_comb begin
      load_en = '0;
      if (accept) begin
         if (in_sop) begin
            load_en[0] = 1'b1;
         end else begin
            load_en[idx_q] = 1'b1;
         end
      end
   end

   assign rdy_en_d = 1'b1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         idx_q      <= '0;
         cnt_q      <= '0;
         sync_err_q <= '0;
         rdy_en_q   <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         sync_err_q <= sync_err_d;
         rdy_en_q   <= rdy_en_d;
      end
   end

   // ---------------- operand registers ----------------
   for (genvar gi = 0; gi < NUM_OPND; gi++) begin : g_opnd
      logic [WIDTH-1:0] opnd_q, opnd_d;

      always_comb begin
         opnd_d = opnd_q;
         if (load_en[gi]) begin
            opnd_d = in_data;
         end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            opnd_q <= '0;
         end else begin
            opnd_q <= opnd_d;
         end
      end

      assign opnd[gi] = opnd_q;
   end

   assign a        = opnd[0];
   assign b        = opnd[1];
   assign c        = opnd[2];
   assign d        = opnd[3];
   assign sync_err = sync_err_q;

   // ---------------- result holding register ----------------
   result_reg #(
      .DW (2*WIDTH)
   ) u_result_reg (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .capture  (capture),
      .drain    (res_ready),
      .cap_data (y_in),
      .valid    (res_valid),
      .data     (res_data)
   );

endmodule
